// File: rtl/tt_ctrl_drv_pkg.sv
// rtl/tt_ctrl_drv_pkg.sv - shared state encoding and phase-length defaults for tt_ctrl_drv
package tt_ctrl_drv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DISABLE = 3'd1,
    ST_RESET   = 3'd2,
    ST_RELEASE = 3'd3,
    ST_INC_HI  = 3'd4,
    ST_INC_LO  = 3'd5,
    ST_ENABLE  = 3'd6
  } state_e;

  localparam int DEF_ADDR_W       = 10;
  localparam int DEF_GAP_CYCLES   = 2;
  localparam int DEF_RST_CYCLES   = 4;
  localparam int DEF_PULSE_CYCLES = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tt_ctrl_drv_if.sv
// rtl/tt_ctrl_drv_if.sv - request, status and mux-controller signals of tt_ctrl_drv
// master: housekeeping side (drives req_*); slave: tt_ctrl_drv (drives status and ctrl_*)
interface tt_ctrl_drv_if #(
  parameter int ADDR_W = 10
);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ena;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] cur_addr;
  logic              cur_valid;
  logic              ctrl_sel_rst_n;
  logic              ctrl_sel_inc;
  logic              ctrl_ena;

  modport master (
    output req_valid, req_addr, req_ena,
    input  req_ready, busy, done, cur_addr, cur_valid,
    input  ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena
  );

  modport slave (
    input  req_valid, req_addr, req_ena,
    output req_ready, busy, done, cur_addr, cur_valid,
    output ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena
  );

endinterface

// File: rtl/tt_ctrl_drv_timer.sv
// rtl/tt_ctrl_drv_timer.sv - loadable down-counter timing each sequencer phase
// clk, rst: clock, async active-high reset
// load, load_val: load phase length minus one; zero: count has expired
module tt_ctrl_drv_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/tt_ctrl_drv.sv
// rtl/tt_ctrl_drv.sv - sequencer driving the mux controller select/enable lines per address request
// clk, rst: clock, async active-high reset
// bus (slave): req_valid/req_ready/req_addr/req_ena request, busy/done/cur_addr/cur_valid status,
//              ctrl_sel_rst_n/ctrl_sel_inc/ctrl_ena to the mux controller
// TT_CTRL_DRV_INCREMENTAL_EN: skip the counter reset when the target is at or above the current address
module tt_ctrl_drv
  import tt_ctrl_drv_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
  parameter int RST_CYCLES   = DEF_RST_CYCLES,
  parameter int PULSE_CYCLES = DEF_PULSE_CYCLES
) (
  input logic          clk,
  input logic          rst,
  tt_ctrl_drv_if.slave bus
);

  localparam int TW = $clog2(max3(GAP_CYCLES, RST_CYCLES, PULSE_CYCLES)) + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ena_lat_q, ena_lat_d;
  logic              skip_q, skip_d;
  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic              cur_valid_q, cur_valid_d;
  logic              sel_rst_n_q, sel_rst_n_d;
  logic              sel_inc_q, sel_inc_d;
  logic              ena_q, ena_d;

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_zero;
  logic          go_inc;
  logic          go_en;

  tt_ctrl_drv_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    ena_lat_d   = ena_lat_q;
    skip_d      = skip_q;
    req_ready_d = req_ready_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cur_addr_d  = cur_addr_q;
    cur_valid_d = cur_valid_q;
    sel_rst_n_d = sel_rst_n_q;
    sel_inc_d   = sel_inc_q;
    ena_d       = ena_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    go_inc      = 1'b0;
    go_en       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          state_d     = ST_DISABLE;
          addr_d      = bus.req_addr;
          ena_lat_d   = bus.req_ena;
          cnt_d       = bus.req_addr;
          skip_d      = 1'b0;
          ena_d       = 1'b0;
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
          tmr_load    = 1'b1;
          tmr_val     = TW'(GAP_CYCLES - 1);
`ifdef TT_CTRL_DRV_INCREMENTAL_EN
          // The counter already holds cur_addr, so only the difference is pulsed.
          if (cur_valid_q && (bus.req_addr >= cur_addr_q)) begin
            skip_d = 1'b1;
            cnt_d  = bus.req_addr - cur_addr_q;
          end
`endif
        end
      end
      ST_DISABLE: begin
        if (tmr_zero) begin
          if (skip_q) begin
            if (cnt_q == '0) go_en = 1'b1;
            else             go_inc = 1'b1;
          end else begin
            state_d     = ST_RESET;
            sel_rst_n_d = 1'b0;
            cur_valid_d = 1'b0;
            tmr_load    = 1'b1;
            tmr_val     = TW'(RST_CYCLES - 1);
          end
        end
      end
      ST_RESET: begin
        if (tmr_zero) begin
          state_d     = ST_RELEASE;
          sel_rst_n_d = 1'b1;
          tmr_load    = 1'b1;
          tmr_val     = TW'(PULSE_CYCLES - 1);
        end
      end
      ST_RELEASE, ST_INC_LO: begin
        if (tmr_zero) begin
          if (cnt_q == '0) go_en = 1'b1;
          else             go_inc = 1'b1;
        end
      end
      ST_INC_HI: begin
        if (tmr_zero) begin
          state_d   = ST_INC_LO;
          sel_inc_d = 1'b0;
          cnt_d     = cnt_q - ADDR_W'(1);
          tmr_load  = 1'b1;
          tmr_val   = TW'(PULSE_CYCLES - 1);
        end
      end
      ST_ENABLE: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        busy_d      = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (go_inc) begin
      state_d   = ST_INC_HI;
      sel_inc_d = 1'b1;
      tmr_load  = 1'b1;
      tmr_val   = TW'(PULSE_CYCLES - 1);
    end

    if (go_en) begin
      state_d     = ST_ENABLE;
      ena_d       = ena_lat_q;
      cur_addr_d  = addr_q;
      cur_valid_d = 1'b1;
      done_d      = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      ena_lat_q   <= 1'b0;
      skip_q      <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cur_addr_q  <= '0;
      cur_valid_q <= 1'b0;
      sel_rst_n_q <= 1'b0;
      sel_inc_q   <= 1'b0;
      ena_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      ena_lat_q   <= ena_lat_d;
      skip_q      <= skip_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cur_addr_q  <= cur_addr_d;
      cur_valid_q <= cur_valid_d;
      sel_rst_n_q <= sel_rst_n_d;
      sel_inc_q   <= sel_inc_d;
      ena_q       <= ena_d;
    end
  end

  assign bus.req_ready      = req_ready_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.cur_addr       = cur_addr_q;
  assign bus.cur_valid      = cur_valid_q;
  assign bus.ctrl_sel_rst_n = sel_rst_n_q;
  assign bus.ctrl_sel_inc   = sel_inc_q;
  assign bus.ctrl_ena       = ena_q;

endmodule

// File: tb/tb_tt_ctrl_drv.sv
// tb/tb_tt_ctrl_drv.sv - directed scoreboard bench for tt_ctrl_drv
module tb_tt_ctrl_drv;

  localparam int GAP   = 2;
  localparam int RSTC  = 4;
  localparam int PULSE = 2;

  typedef struct {
    int   lat;
    int   pulses;
    int   rstlow;
    logic ena;
    int   addr;
  } exp_t;

  logic clk;
  logic rst;

  tt_ctrl_drv_if #(.ADDR_W(10)) bus ();

  tt_ctrl_drv dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  int   mcur = 0;
  bit   mvalid = 1'b0;
  bit   fresh = 1'b1;

  int   cyc = 0;
  int   acc_cyc = 0;
  int   mon_pulses = 0;
  int   mon_rstlow = 0;
  bit   tracking = 1'b0;
  bit   done_seen = 1'b0;
  logic prev_inc = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t model(input int addr, input bit ena);
    exp_t e;
    bit   skip;
    int   n;
    skip = 1'b0;
`ifdef TT_CTRL_DRV_INCREMENTAL_EN
    if (mvalid && addr >= mcur) skip = 1'b1;
`endif
    n        = skip ? (addr - mcur) : addr;
    e.lat    = GAP + (skip ? 0 : RSTC + PULSE) + 2 * PULSE * n + 1;
    e.pulses = n;
    e.rstlow = skip ? 0 : RSTC + (fresh ? GAP : 0);
    e.ena    = ena;
    e.addr   = addr;
    return e;
  endfunction

  // Acceptance is observed with pre-edge values.
  always @(posedge clk) begin
    cyc++;
    if (!rst && bus.req_valid && bus.req_ready) begin
      acc_cyc    = cyc;
      mon_pulses = 0;
      mon_rstlow = 0;
      tracking   = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      tracking = 1'b0;
      prev_inc = 1'b0;
    end else begin
      chk("mutex_inc_rst", 32'(bus.ctrl_sel_inc & ~bus.ctrl_sel_rst_n), 0);
      chk("ena_while_seq", 32'(bus.ctrl_ena & bus.busy & ~bus.done), 0);
      if (tracking) begin
        if (bus.ctrl_sel_inc && !prev_inc) mon_pulses++;
        if (!bus.ctrl_sel_rst_n) mon_rstlow++;
      end
      if (bus.done) begin
        chk("done_expected", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("latency", cyc - acc_cyc + 1, e.lat);
          chk("pulses", mon_pulses, e.pulses);
          chk("rst_low_cycles", mon_rstlow, e.rstlow);
          chk("ctrl_ena", 32'(bus.ctrl_ena), 32'(e.ena));
          chk("cur_addr", 32'(bus.cur_addr), e.addr);
          chk("cur_valid", 32'(bus.cur_valid), 1);
          chk("ready_in_done", 32'(bus.req_ready), 0);
        end
        tracking  = 1'b0;
        done_seen = 1'b1;
      end
      prev_inc = bus.ctrl_sel_inc;
    end
  end

  task automatic do_req(input int addr, input bit ena, input bit hold);
    exp_t e;
    int   budget;
    e = model(addr, ena);
    sb.push_back(e);
    mcur   = addr;
    mvalid = 1'b1;
    fresh  = 1'b0;
    budget = e.lat + 20;
    @(negedge clk);
    done_seen     = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_addr  = 10'(addr);
    bus.req_ena   = ena;
    @(posedge clk);
    #1;
    chk("ready_after_accept", 32'(bus.req_ready), 0);
    chk("busy_after_accept", 32'(bus.busy), 1);
    chk("ena_falls", 32'(bus.ctrl_ena), 0);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (done_seen) break;
      if (hold) begin
        bus.req_addr = 10'($urandom);
        bus.req_ena  = 1'($urandom);
      end else begin
        bus.req_valid = 1'b0;
        bus.req_addr  = 10'($urandom);
      end
    end
    chk("done_within_budget", 32'(done_seen), 1);
    bus.req_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("ready_after_done", 32'(bus.req_ready), 1);
    chk("busy_after_done", 32'(bus.busy), 0);
    chk("done_one_cycle", 32'(bus.done), 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sel_rst_n"}, 32'(bus.ctrl_sel_rst_n), 0);
    chk({tag, "_sel_inc"}, 32'(bus.ctrl_sel_inc), 0);
    chk({tag, "_ena"}, 32'(bus.ctrl_ena), 0);
    chk({tag, "_ready"}, 32'(bus.req_ready), 1);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_cur_addr"}, 32'(bus.cur_addr), 0);
    chk({tag, "_cur_valid"}, 32'(bus.cur_valid), 0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_ena   = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("post_reset");

    do_req(3, 1'b1, 1'b0);
    do_req(0, 1'b0, 1'b0);
    do_req(3, 1'b1, 1'b0);
    do_req(5, 1'b1, 1'b0);
    do_req(5, 1'b0, 1'b0);
    do_req(2, 1'b1, 1'b0);
    do_req(1023, 1'b1, 1'b0);

    // Reset during the second increment-high phase of an addr=3 request.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = 10'd3;
    bus.req_ena   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    begin
      int i;
      for (i = 0; i < 100; i++) begin
        @(negedge clk);
        #1;
        if (mon_pulses == 2) break;
      end
      chk("reached_2nd_inc_hi", mon_pulses, 2);
    end
    chk("inc_high_before_rst", 32'(bus.ctrl_sel_inc), 1);
    rst = 1'b1;
    #1;
    chk_reset_vals("midop_reset");
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    mcur   = 0;
    mvalid = 1'b0;
    fresh  = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      chk("no_done_after_reset", 32'(bus.done), 0);
    end

    do_req(3, 1'b1, 1'b0);
    do_req(4, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
